// File: rtl/controle_estoque_rolhas.sv
// Cork magazine stock controller for the bottling line.
// Counts corks used per seal and sequences refills through a req/ack handshake.
module controle_estoque_rolhas #(
    parameter int CAP        = 99,
    parameter int INIT_STOCK = 99,
    parameter int LOW_MARK   = 5,
    parameter int REFILL_QTY = 15,
    parameter int TIMEOUT    = 250
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       enable,
    input  logic       ve,
    input  logic       refill_ack,
    output logic       refill_req,
    output logic       seal_inhibit,
    output logic       al_rolha,
    output logic       low_stock,
    output logic [6:0] count,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        REFILL = 3'd2,
        EMPTY  = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [7:0]  CAP8  = 8'(CAP);
    localparam logic [7:0]  LOW8  = 8'(LOW_MARK);
    localparam logic [7:0]  QTY8  = 8'(REFILL_QTY);
    localparam logic [6:0]  INIT7 = 7'(INIT_STOCK);
    localparam logic [6:0]  LOW7  = 7'(LOW_MARK);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      st_q, st_d;
    logic        ve_q;
    logic [15:0] timer_q, timer_d;
    logic [6:0]  count_d;
    logic        use_c, acc;
    logic [7:0]  sum, sat, cn;
    logic        cn_zero, cn_low;
    logic [6:0]  tens_w, units_w;

    // Stock arithmetic: add an accepted batch, saturate, then take one cork
    always_comb begin
        use_c   = ve & ~ve_q & ((st_q == RUN) | (st_q == REFILL));
        acc     = refill_req & refill_ack;
        sum     = {1'b0, count} + (acc ? QTY8 : 8'd0);
        sat     = (sum > CAP8) ? CAP8 : sum;
        cn      = (use_c && sat != 8'd0) ? sat - 8'd1 : sat;
        cn_zero = (cn == 8'd0);
        cn_low  = (cn <= LOW8);
    end

    // Next state, next timer and next count
    always_comb begin
        st_d    = st_q;
        timer_d = timer_q;
        count_d = cn[6:0];
        if (!enable) begin
            st_d    = IDLE;
            timer_d = 16'd0;
            count_d = count;
        end else begin
            unique case (st_q)
                IDLE: begin
                    st_d    = RUN;
                    timer_d = 16'd0;
                end
                RUN: begin
                    timer_d = 16'd0;
                    if (cn_zero)     st_d = EMPTY;
                    else if (cn_low) st_d = REFILL;
                end
                REFILL, EMPTY: begin
                    if (acc) begin
                        timer_d = 16'd0;
                        if (cn_zero)     st_d = EMPTY;
                        else if (cn_low) st_d = REFILL;
                        else             st_d = RUN;
                    end else if (timer_q >= TO_LAST) begin
                        st_d    = FAULT;
                        timer_d = 16'd0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                        if (cn_zero) st_d = EMPTY;
                    end
                end
                FAULT: begin
                    timer_d = 16'd0;
                end
                default: begin
                    st_d    = IDLE;
                    timer_d = 16'd0;
                end
            endcase
        end
    end

    // State, stock, timer and outputs registered from the next state
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st_q         <= IDLE;
            count        <= INIT7;
            timer_q      <= 16'd0;
            ve_q         <= 1'b0;
            refill_req   <= 1'b0;
            seal_inhibit <= 1'b0;
            al_rolha     <= 1'b0;
        end else begin
            st_q         <= st_d;
            count        <= count_d;
            timer_q      <= timer_d;
            ve_q         <= ve;
            refill_req   <= (st_d == REFILL) | (st_d == EMPTY);
            seal_inhibit <= (st_d == EMPTY) | (st_d == FAULT);
            al_rolha     <= (st_d == EMPTY) | (st_d == FAULT);
        end
    end

    // Display digits and low-stock flag derived from the registered count
    always_comb begin
        tens_w    = count / 7'd10;
        units_w   = count % 7'd10;
        bcd_tens  = tens_w[3:0];
        bcd_units = units_w[3:0];
        low_stock = (count <= LOW7);
        state     = st_q;
    end

endmodule
